// File: rtl/mesh_term_adapter.sv
// rtl/mesh_term_adapter.sv - NTERM-channel TX/RX FIFO adapter for mesh_gnrtr edge ports
// Optional TX watchdog enabled by defining MESH_TERM_TIMEOUT_EN.
module mesh_term_adapter #(
  parameter int NTERM      = 16,
  parameter int pckg_sz    = 32,
  parameter int fifo_depth = 8,
  parameter int TO_CYC     = 256
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NTERM-1:0]         tx_push,
  input  logic [NTERM*pckg_sz-1:0] tx_data,
  output logic [NTERM-1:0]         tx_full,
  output logic [NTERM-1:0]         mesh_pndng_in,
  output logic [NTERM*pckg_sz-1:0] mesh_data_in,
  input  logic [NTERM-1:0]         mesh_popin,
  input  logic [NTERM-1:0]         mesh_pndng,
  input  logic [NTERM*pckg_sz-1:0] mesh_data_out,
  output logic [NTERM-1:0]         mesh_pop,
  output logic [NTERM-1:0]         rx_pndng,
  output logic [NTERM*pckg_sz-1:0] rx_data,
  input  logic [NTERM-1:0]         rx_pop,
  output logic [NTERM-1:0]         tx_timeout
);

  localparam int PW = $clog2(fifo_depth);
  localparam int CW = $clog2(fifo_depth + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(fifo_depth);

  typedef enum logic {S_IDLE, S_POP} rx_state_t;

  if (fifo_depth < 2 || TO_CYC < 1) begin : g_bad_param
    $error("mesh_term_adapter: fifo_depth must be >= 2 and TO_CYC >= 1");
  end

  for (genvar g = 0; g < NTERM; g++) begin : g_ch
    logic [pckg_sz-1:0] r_tx_mem [fifo_depth];
    logic [PW-1:0]      r_tx_rd, r_tx_wr;
    logic [CW-1:0]      r_tx_cnt;
    logic               w_tx_push, w_tx_pop;

    logic [pckg_sz-1:0] r_rx_mem [fifo_depth];
    logic [PW-1:0]      r_rx_rd, r_rx_wr;
    logic [CW-1:0]      r_rx_cnt;
    logic               w_rx_wr, w_rx_rd;
    rx_state_t          r_rx_state;
    logic               r_mesh_pop;

    // A push while full is dropped even if the mesh pops in the same cycle.
    assign w_tx_push = tx_push[g] && (r_tx_cnt != FULL_CNT);
    assign w_tx_pop  = mesh_popin[g] && (r_tx_cnt != '0);

    always_ff @(posedge clk) begin
      if (w_tx_push) r_tx_mem[r_tx_wr] <= tx_data[g*pckg_sz +: pckg_sz];
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_tx_rd  <= '0;
        r_tx_wr  <= '0;
        r_tx_cnt <= '0;
      end else begin
        if (w_tx_push) r_tx_wr <= r_tx_wr + 1'b1;
        if (w_tx_pop)  r_tx_rd <= r_tx_rd + 1'b1;
        case ({w_tx_push, w_tx_pop})
          2'b10:   r_tx_cnt <= r_tx_cnt + 1'b1;
          2'b01:   r_tx_cnt <= r_tx_cnt - 1'b1;
          default: r_tx_cnt <= r_tx_cnt;
        endcase
      end
    end

    assign tx_full[g]       = (r_tx_cnt == FULL_CNT);
    assign mesh_pndng_in[g] = (r_tx_cnt != '0);
    assign mesh_data_in[g*pckg_sz +: pckg_sz] = (r_tx_cnt != '0) ? r_tx_mem[r_tx_rd] : '0;

    // The IDLE check uses pre-edge occupancy, so the POP-cycle write always fits.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_rx_state <= S_IDLE;
        r_mesh_pop <= 1'b0;
      end else begin
        case (r_rx_state)
          S_IDLE: begin
            if (mesh_pndng[g] && (r_rx_cnt != FULL_CNT)) begin
              r_mesh_pop <= 1'b1;
              r_rx_state <= S_POP;
            end
          end
          S_POP: begin
            r_mesh_pop <= 1'b0;
            r_rx_state <= S_IDLE;
          end
          default: begin
            r_mesh_pop <= 1'b0;
            r_rx_state <= S_IDLE;
          end
        endcase
      end
    end

    assign w_rx_wr = (r_rx_state == S_POP);
    assign w_rx_rd = rx_pop[g] && (r_rx_cnt != '0);

    always_ff @(posedge clk) begin
      if (w_rx_wr) r_rx_mem[r_rx_wr] <= mesh_data_out[g*pckg_sz +: pckg_sz];
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_rx_rd  <= '0;
        r_rx_wr  <= '0;
        r_rx_cnt <= '0;
      end else begin
        if (w_rx_wr) r_rx_wr <= r_rx_wr + 1'b1;
        if (w_rx_rd) r_rx_rd <= r_rx_rd + 1'b1;
        case ({w_rx_wr, w_rx_rd})
          2'b10:   r_rx_cnt <= r_rx_cnt + 1'b1;
          2'b01:   r_rx_cnt <= r_rx_cnt - 1'b1;
          default: r_rx_cnt <= r_rx_cnt;
        endcase
      end
    end

    assign mesh_pop[g] = r_mesh_pop;
    assign rx_pndng[g] = (r_rx_cnt != '0);
    assign rx_data[g*pckg_sz +: pckg_sz] = (r_rx_cnt != '0) ? r_rx_mem[r_rx_rd] : '0;

`ifdef MESH_TERM_TIMEOUT_EN
    localparam int TW = $clog2(TO_CYC + 1);
    localparam logic [TW-1:0] TO_LIM = TW'(TO_CYC);
    logic [TW-1:0] r_wd, w_wd_nxt;
    logic          r_to;

    always_comb begin
      w_wd_nxt = r_wd;
      if (mesh_popin[g] || (r_tx_cnt == '0)) w_wd_nxt = '0;
      else if (r_wd != TO_LIM)               w_wd_nxt = r_wd + 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_wd <= '0;
        r_to <= 1'b0;
      end else begin
        r_wd <= w_wd_nxt;
        if (w_wd_nxt == TO_LIM) r_to <= 1'b1;
      end
    end

    assign tx_timeout[g] = r_to;
`else
    assign tx_timeout[g] = 1'b0;
`endif
  end

endmodule

// File: doc/mesh_term_adapter.md
# mesh_term_adapter

Multi-channel terminal adapter between local traffic sources/sinks and the edge ports of `mesh_gnrtr`. It generalises the single-terminal pndng/popin/pop handshake into NTERM independent channels. Each channel has a transmit FIFO that presents packets to the mesh and a receive FIFO that drains the mesh output. A per-channel watchdog flags packets the mesh never accepts.

## Interface
Parameters:
- `NTERM`, 16, number of terminal channels (ROWS*2+COLUMS*2 for the target mesh).
- `pckg_sz`, 32, packet width in bits.
- `fifo_depth`, 8, entries per TX FIFO and per RX FIFO (power of two, ≥2).
- `TO_CYC`, 256, watchdog threshold in cycles (≥1).

Ports:
- `clk`, in, 1, single clock; all logic is rising-edge.
- `reset`, in, 1, asynchronous, active-low; clears all state.
- `tx_push`, in, NTERM, per-channel write strobe from the local source.
- `tx_data`, in, NTERM*pckg_sz, push data; channel i uses bits [i*pckg_sz +: pckg_sz].
- `tx_full`, out, NTERM, TX FIFO full.
- `mesh_pndng_in`, out, NTERM, to mesh `pndng_i_in`; high when the TX FIFO is non-empty.
- `mesh_data_in`, out, NTERM*pckg_sz, to mesh `data_out_i_in`; TX FIFO head.
- `mesh_popin`, in, NTERM, from mesh `popin`; mesh consumed the head.
- `mesh_pndng`, in, NTERM, from mesh `pndng`; a packet is waiting at the output.
- `mesh_data_out`, in, NTERM*pckg_sz, from mesh `data_out`.
- `mesh_pop`, out, NTERM, to mesh `pop`; registered one-cycle strobe.
- `rx_pndng`, out, NTERM, RX FIFO non-empty.
- `rx_data`, out, NTERM*pckg_sz, RX FIFO head.
- `rx_pop`, in, NTERM, local sink dequeue strobe.
- `tx_timeout`, out, NTERM, sticky watchdog flag (see Configuration).

## Operation
- **Channel independence:** channels are fully independent; no arbitration between them.
- **TX FIFO:** circular buffer with a read pointer, a write pointer and an occupancy count of width $clog2(fifo_depth+1).
  - Push is accepted when `tx_push`=1 and the pre-edge `tx_full`=0.
  - A push while full is ignored, even if a pop occurs in the same cycle.
  - Pop occurs on `mesh_popin`=1 when the FIFO is non-empty. `mesh_popin` with the FIFO empty is ignored.
  - Simultaneous push and pop with the FIFO not full: both take effect and the count is unchanged.
  - `mesh_data_in` equals the head entry; it is 0 when empty.
- **RX side:** per-channel two-state FSM.
  - IDLE: if `mesh_pndng`=1 and the RX FIFO is not full, set `mesh_pop`<=1 and go to POP.
  - POP: write `mesh_data_out` into the RX FIFO, set `mesh_pop`<=0, return to IDLE.
  - The mandatory IDLE cycle lets the mesh update `pndng`. Maximum drain rate is one packet every 2 cycles per channel.
  - A full RX FIFO back-pressures the mesh: `mesh_pop` is withheld and nothing is lost.
- **RX FIFO local side:** `rx_pop` with `rx_pndng`=1 dequeues the head. `rx_pop` when empty is ignored. A simultaneous RX write and `rx_pop` are both honoured.
- **Pointer wrap:** pointers wrap modulo `fifo_depth`.

## Timing
- **Reset values:** all FIFOs empty; `tx_full`, `mesh_pndng_in`, `mesh_pop`, `rx_pndng`, `tx_timeout` = 0; `mesh_data_in` and `rx_data` = 0; FSMs in IDLE; watchdog counters = 0.
- **TX latency:** `mesh_pndng_in` rises 1 cycle after the accepting `tx_push` edge.
- **RX latency:** the sequence from `mesh_pndng` rising to `rx_pndng` rising takes 2 edges (`mesh_pop` is asserted after the first; data is written on the second).
- **Flag timing:** `tx_full` and `rx_pndng` reflect post-edge occupancy.
- **Reset mid-operation:** a `reset` low asynchronously empties both FIFOs and drops `mesh_pop` immediately. A packet in flight in the POP state is discarded.

## Configuration
- **Macro:** `MESH_TERM_TIMEOUT_EN`.
- **Defined:** each channel has a counter of width $clog2(TO_CYC+1).
  - The counter increments each cycle `mesh_pndng_in`=1 and `mesh_popin`=0.
  - It clears on `mesh_popin`=1 or when the TX FIFO is empty, and saturates at `TO_CYC`.
  - When it reaches `TO_CYC`, `tx_timeout[i]` is set. The flag is sticky and cleared only by `reset`.
- **Undefined:** no counters are synthesised and `tx_timeout` is tied to 0.

## Test plan
- **Reset:** hold `reset`=0 for 3 cycles with random inputs -> every output is 0 throughout; after release, `mesh_pndng_in`=0 and `rx_pndng`=0.
- **Single path:** push 32'h00FF_D52A on channel 0; mesh asserts `mesh_popin[0]` 3 cycles later -> `mesh_pndng_in[0]` high for exactly those cycles and `mesh_data_in` = 00FF_D52A; then loop `mesh_pndng[15]` with the same data -> `mesh_pop[15]` pulses once and `rx_data[15]` = 00FF_D52A, `rx_pndng[15]`=1.
- **TX full:** push 9 words 1..9 on channel 3 with no `mesh_popin` -> `tx_full[3]`=1 after the 8th push; word 9 is dropped; the pop sequence yields 1..8 in order, exercising pointer wrap.
- **RX back-pressure:** hold `mesh_pndng[5]`=1 with no `rx_pop` -> exactly 8 `mesh_pop` pulses, spaced 2 cycles apart, then none. A single `rx_pop` -> one further pulse.
- **Simultaneous events:** TX count=4 on channel 2, then `tx_push` and `mesh_popin` in the same cycle -> count stays 4 and the head advances.
- **Watchdog (macro defined, `TO_CYC`=16):** push one word and never assert `mesh_popin` -> `tx_timeout[1]` rises after cycle 16 and stays high after a later `mesh_popin`. With the macro undefined -> stays 0.
